fechadura_ctrl: RTL
===================

// Module: fechadura_ctrl
// PURPOSE
//  Top-level sequencer of the keypad door lock. Checks keypad entries against the stored passwords.
//  Drives the bolt, the auto-lock and door-open beep timers, and the wrong-password lockout.
//  Hands the keypad and display to the setup block while setup is active.
//  Sits between the keypad decoder, the setup block, the display driver and the bolt/buzzer outputs.
// PARAMETERS
//  CLK_HZ         1000  clock cycles per 1 s tick (prescaler terminal count + 1)
//  MAX_TENTATIVAS 5     consecutive wrong entries that trigger lockout (1..15)
//  BLOQUEIO_S     30    lockout duration in seconds (1..99)
// PORTS
//  clk             in   1           system clock, rising edge
//  rst             in   1           asynchronous reset, active-high
//  digitos_value   in   senhaPac_t  20 BCD nibbles; unused digits = 'hF
//  digitos_valid   in   1           1-cycle strobe, digitos_value is complete
//  botao_interno   in   1           1-cycle pulse, inside push-button
//  sensor_porta    in   1           1 = door closed, 0 = door open
//  data_setup_new  in   setupPac_t  new configuration from the setup block
//  data_setup_ok   in   1           1-cycle strobe, data_setup_new is valid
//  setup_on        out  1           high for the whole SETUP state
//  tranca          out  1           1 = bolt locked
//  bip             out  1           buzzer enable
//  teclado_en      out  1           keypad accepted; 0 in BLOQUEADA
//  display_en      out  1           this block owns the display
//  bcd_pac         out  bcdPac_t    6 BCD digits, 'hB = blank
// BEHAVIOUR
//  Reset (async) values:
//   - State TRANCADA; tranca=1; bip=0; setup_on=0; teclado_en=1; display_en=0; bcd_pac='hBBBBBB.
//   - Attempt counter = 0.
//   - cfg: bip_ativado=1, bip_time=5, tranca_aut_time=5, senha_master=1234, senha_1..4 = all 'hF.
//  Seconds tick: prescaler counts 0..CLK_HZ-1. It is cleared on every state entry, so an N-second timer expires exactly N*CLK_HZ cycles after entry. Second counters are 7-bit binary.
//  Match: digitos_value.digits == slot.digits for any of master or 1..4.
//   - Slots that are all 'hF never match. An all-'hF entry is ignored (no attempt counted).
//  digitos_valid is ignored when teclado_en=0.
//  All outputs are registered or decoded from state; response is 1 cycle after the strobe.
//  TRANCADA: tranca=1.
//   - botao_interno -> DESTR_FECHADA; this has priority over a same-cycle digitos_valid, which is dropped.
//   - Valid match -> DESTR_FECHADA and clear attempts.
//   - Valid mismatch -> attempts+1. Reaching MAX_TENTATIVAS -> BLOQUEADA, attempts cleared.
//   - sensor_porta=0 (forced door) -> bip=1 while open, independent of bip_ativado; stays TRANCADA.
//  BLOQUEADA: tranca=1; teclado_en=0; display_en=1; bcd_pac='hBBBB + 2-digit BCD of remaining seconds.
//   - After BLOQUEIO_S s -> TRANCADA. botao_interno -> DESTR_FECHADA.
//  DESTR_FECHADA: tranca=0.
//   - sensor_porta=0 -> PORTA_ABERTA.
//   - botao_interno -> TRANCADA.
//   - Valid entry == senha_master -> SETUP. Other entries are ignored.
//   - tranca_aut_time s elapsed with door closed -> TRANCADA.
//  PORTA_ABERTA: tranca=0. After bip_time s, bip=cfg.bip_ativado until the door closes.
//   - sensor_porta=1 -> DESTR_FECHADA (auto-lock restarts), bip=0 in the same transition.
//  SETUP: tranca=0; setup_on=1; display_en=0 (setup owns keypad and display).
//   - data_setup_ok -> cfg <= data_setup_new, then -> DESTR_FECHADA.
//   - Door opening in SETUP is ignored.
//  Timer values from cfg are binary, already clamped to 5..60 by setup; no re-clamping here.
//  Simultaneous events:
//   - Door-open has priority over auto-lock expiry in the same cycle.
//   - A timer expiring on the same cycle as botao_interno resolves to TRANCADA.
//  Reset mid-operation: immediate return to reset values, including cfg defaults and attempt count.
//  Unreachable state encodings -> TRANCADA.
// TESTING
//  1. Reset; digitos 1234 + valid -> tranca=0 next cycle, state DESTR_FECHADA.
//  2. 5 valid entries of 9999 -> teclado_en=0, bcd_pac='hBBBB30.
//     A valid 1234 in BLOQUEADA is ignored; after 30*CLK_HZ cycles -> TRANCADA, teclado_en=1.
//  3. Unlock, keep door closed -> tranca returns to 1 exactly 5*CLK_HZ cycles after unlock.
//  4. Unlock, open door and hold -> bip=1 at 5 s; close at 8 s -> bip=0; tranca=1 5 s later.
//  5. Unlock, enter 1234 -> setup_on=1.
//     data_setup_ok with master=9876, bip_time=10 -> setup_on=0.
//     After lock, 1234 counts a failure; 9876 unlocks.
//  6. Locked, sensor_porta=0 with bip_ativado=0 -> bip=1.
//     botao_interno and a wrong digitos_valid in the same cycle -> unlock, attempts unchanged.

Source files
------------

// File: rtl/fechadura_ctrl.sv
// Keypad door-lock sequencer: password check, bolt, auto-lock and door-open beep timers, lockout.
// Flat setup packet: {bip_ativado, bip_time[6:0], tranca_aut_time[6:0], master, senha_1..4}; passwords are 20 BCD nibbles, unused = 'hF.
module fechadura_ctrl #(
  parameter int CLK_HZ         = 1000,
  parameter int MAX_TENTATIVAS = 5,
  parameter int BLOQUEIO_S     = 30
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [79:0]  digitos_value_i,
  input  logic         digitos_valid_i,
  input  logic         botao_interno_i,
  input  logic         sensor_porta_i,
  input  logic [414:0] data_setup_new_i,
  input  logic         data_setup_ok_i,
  output logic         setup_on_o,
  output logic         tranca_o,
  output logic         bip_o,
  output logic         teclado_en_o,
  output logic         display_en_o,
  output logic [23:0]  bcd_pac_o
);

  localparam logic [2:0] TRANCADA      = 3'd0;
  localparam logic [2:0] BLOQUEADA     = 3'd1;
  localparam logic [2:0] DESTR_FECHADA = 3'd2;
  localparam logic [2:0] PORTA_ABERTA  = 3'd3;
  localparam logic [2:0] SETUP         = 3'd4;

  localparam int         PW          = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] PRESC_TC = PW'(CLK_HZ - 1);
  localparam logic [6:0] BLOQ_S      = 7'(BLOQUEIO_S);
  localparam logic [3:0] MAX_TENT    = 4'(MAX_TENTATIVAS);
  localparam logic [79:0] SENHA_VAZIA      = {20{4'hF}};
  localparam logic [79:0] SENHA_MASTER_RST = {{16{4'hF}}, 16'h1234};

  logic [2:0]       state_q, state_d;
  logic [3:0]       tent_q, tent_d;
  logic             bip_q, bip_d;
  logic [PW-1:0]    presc_q;
  logic [6:0]       sec_q;
  logic             cfg_bip_at_q;
  logic [6:0]       cfg_bip_time_q, cfg_aut_time_q;
  logic [79:0]      cfg_master_q;
  logic [3:0][79:0] cfg_senha_q;

  logic       tick, fim_aut, fim_bip, fim_bloq;
  logic       entrada_ok, eh_master, match;
  logic [6:0] sec_prox;

  function automatic logic [7:0] bcd2(input logic [6:0] v);
    bcd2 = {4'(v / 7'd10), 4'(v % 7'd10)};
  endfunction

  assign tick     = (presc_q == PRESC_TC);
  assign sec_prox = sec_q + 7'd1;
  // Timer N fires on the N-th tick after entry, i.e. N*CLK_HZ cycles later.
  assign fim_aut  = tick && (sec_prox == cfg_aut_time_q);
  assign fim_bip  = tick && (sec_prox == cfg_bip_time_q);
  assign fim_bloq = tick && (sec_prox == BLOQ_S);

  always_comb begin
    entrada_ok = digitos_valid_i && (digitos_value_i != SENHA_VAZIA);
    eh_master  = (cfg_master_q != SENHA_VAZIA) && (digitos_value_i == cfg_master_q);
    match      = eh_master;
    for (int i = 0; i < 4; i++) begin
      if (cfg_senha_q[i] != SENHA_VAZIA && digitos_value_i == cfg_senha_q[i]) match = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    tent_d  = tent_q;
    bip_d   = 1'b0;
    case (state_q)
      TRANCADA: begin
        if (botao_interno_i) begin
          state_d = DESTR_FECHADA;
        end else if (entrada_ok) begin
          if (match) begin
            state_d = DESTR_FECHADA;
            tent_d  = 4'd0;
          end else if (tent_q + 4'd1 == MAX_TENT) begin
            state_d = BLOQUEADA;
            tent_d  = 4'd0;
          end else begin
            tent_d = tent_q + 4'd1;
          end
        end
        if (state_d == TRANCADA) bip_d = !sensor_porta_i;
      end
      BLOQUEADA: begin
        if (fim_bloq)             state_d = TRANCADA;
        else if (botao_interno_i) state_d = DESTR_FECHADA;
      end
      DESTR_FECHADA: begin
        if (!sensor_porta_i)                   state_d = PORTA_ABERTA;
        else if (botao_interno_i || fim_aut)   state_d = TRANCADA;
        else if (entrada_ok && eh_master)      state_d = SETUP;
      end
      PORTA_ABERTA: begin
        if (sensor_porta_i) state_d = DESTR_FECHADA;
        else                bip_d   = bip_q | (fim_bip & cfg_bip_at_q);
      end
      SETUP: begin
        if (data_setup_ok_i) state_d = DESTR_FECHADA;
      end
      default: state_d = TRANCADA;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q        <= TRANCADA;
      tent_q         <= 4'd0;
      bip_q          <= 1'b0;
      presc_q        <= '0;
      sec_q          <= 7'd0;
      cfg_bip_at_q   <= 1'b1;
      cfg_bip_time_q <= 7'd5;
      cfg_aut_time_q <= 7'd5;
      cfg_master_q   <= SENHA_MASTER_RST;
      cfg_senha_q    <= {4{SENHA_VAZIA}};
    end else begin
      state_q <= state_d;
      tent_q  <= tent_d;
      bip_q   <= bip_d;
      if (state_d != state_q) begin
        presc_q <= '0;
        sec_q   <= 7'd0;
      end else if (tick) begin
        presc_q <= '0;
        sec_q   <= sec_prox;
      end else begin
        presc_q <= presc_q + PW'(1);
      end
      if (state_q == SETUP && data_setup_ok_i) begin
        cfg_bip_at_q   <= data_setup_new_i[414];
        cfg_bip_time_q <= data_setup_new_i[413:407];
        cfg_aut_time_q <= data_setup_new_i[406:400];
        cfg_master_q   <= data_setup_new_i[399:320];
        cfg_senha_q    <= data_setup_new_i[319:0];
      end
    end
  end

  assign setup_on_o   = (state_q == SETUP);
  assign tranca_o     = (state_q == TRANCADA) || (state_q == BLOQUEADA);
  assign bip_o        = bip_q;
  assign teclado_en_o = (state_q != BLOQUEADA);
  assign display_en_o = (state_q == BLOQUEADA);
  assign bcd_pac_o    = (state_q == BLOQUEADA) ? {16'hBBBB, bcd2(BLOQ_S - sec_q)} : 24'hBBBBBB;

endmodule
